// File: rtl/grid_write_arbiter.sv
// rtl/grid_write_arbiter.sv - two-port round-robin grid RAM write arbiter with full-grid clear sweep
module grid_write_arbiter #(
    parameter int GRID_LAST = 4095
) (
    input  logic        iVGA_CLK,
    input  logic        iRST_n,
    input  logic        a_req,
    input  logic [11:0] a_addr,
    input  logic [3:0]  a_data,
    output logic        a_ack,
    input  logic        b_req,
    input  logic [11:0] b_addr,
    input  logic [3:0]  b_data,
    output logic        b_ack,
    input  logic        clr_start,
    input  logic [3:0]  clr_color,
    output logic        clr_busy,
    output logic        clr_done,
    output logic        wren_gridData,
    output logic [11:0] wraddress_gridData,
    output logic [3:0]  data_gridData
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    localparam logic [11:0] LAST_ADDR = 12'(GRID_LAST);

    state_t      state_q;
    logic        clr_pend_q;
    logic [3:0]  clr_color_q;
    logic [11:0] cnt_q;
    logic [11:0] cnt_d;
    logic        last_b_q;
    logic        grant_b_d;

    // B wins when it is alone, or when both ask and A was served last
    always_comb begin
        cnt_d     = cnt_q + 12'd1;
        grant_b_d = b_req && (!a_req || !last_b_q);
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q            <= S_IDLE;
            clr_pend_q         <= 1'b0;
            clr_color_q        <= 4'd0;
            cnt_q              <= 12'd0;
            last_b_q           <= 1'b1;
            wren_gridData      <= 1'b0;
            wraddress_gridData <= 12'd0;
            data_gridData      <= 4'd0;
            a_ack              <= 1'b0;
            b_ack              <= 1'b0;
            clr_busy           <= 1'b0;
            clr_done           <= 1'b0;
        end else begin
            wren_gridData <= 1'b0;
            a_ack         <= 1'b0;
            b_ack         <= 1'b0;
            clr_busy      <= 1'b0;
            clr_done      <= 1'b0;

            if (state_q != S_CLEAR && clr_start) begin
                clr_pend_q  <= 1'b1;
                clr_color_q <= clr_color;
            end

            case (state_q)
                S_IDLE: begin
                    // A pending clear consumes the request that started it and outranks both ports
                    if (clr_pend_q) begin
                        state_q            <= S_CLEAR;
                        clr_pend_q         <= 1'b0;
                        cnt_q              <= 12'd0;
                        wren_gridData      <= 1'b1;
                        wraddress_gridData <= 12'd0;
                        data_gridData      <= clr_color_q;
                        clr_busy           <= 1'b1;
                    end else if (a_req || b_req) begin
                        state_q       <= S_WRITE;
                        wren_gridData <= 1'b1;
                        if (grant_b_d) begin
                            wraddress_gridData <= b_addr;
                            data_gridData      <= b_data;
                            b_ack              <= 1'b1;
                            last_b_q           <= 1'b1;
                        end else begin
                            wraddress_gridData <= a_addr;
                            data_gridData      <= a_data;
                            a_ack              <= 1'b1;
                            last_b_q           <= 1'b0;
                        end
                    end
                end
                S_WRITE: begin
                    state_q <= S_IDLE;
                end
                S_CLEAR: begin
                    if (cnt_q == LAST_ADDR) begin
                        state_q  <= S_IDLE;
                        clr_done <= 1'b1;
                    end else begin
                        cnt_q              <= cnt_d;
                        wren_gridData      <= 1'b1;
                        wraddress_gridData <= cnt_d;
                        clr_busy           <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_grid_write_arbiter.sv
// tb/tb_grid_write_arbiter.sv - directed self-checking bench for grid_write_arbiter
module tb_grid_write_arbiter;

    logic        clk;
    logic        rst_n;
    logic        a_req;
    logic [11:0] a_addr;
    logic [3:0]  a_data;
    logic        a_ack;
    logic        b_req;
    logic [11:0] b_addr;
    logic [3:0]  b_data;
    logic        b_ack;
    logic        clr_start;
    logic [3:0]  clr_color;
    logic        clr_busy;
    logic        clr_done;
    logic        wren;
    logic [11:0] waddr;
    logic [3:0]  wdata;

    int total = 0;
    int bad   = 0;

    grid_write_arbiter dut (
        .iVGA_CLK           (clk),
        .iRST_n             (rst_n),
        .a_req              (a_req),
        .a_addr             (a_addr),
        .a_data             (a_data),
        .a_ack              (a_ack),
        .b_req              (b_req),
        .b_addr             (b_addr),
        .b_data             (b_data),
        .b_ack              (b_ack),
        .clr_start          (clr_start),
        .clr_color          (clr_color),
        .clr_busy           (clr_busy),
        .clr_done           (clr_done),
        .wren_gridData      (wren),
        .wraddress_gridData (waddr),
        .data_gridData      (wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {wren, a_ack, b_ack, clr_busy, clr_done, addr, data} packed for compact compares
    function automatic logic [20:0] outs();
        return {wren, a_ack, b_ack, clr_busy, clr_done, waddr, wdata};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        a_req = 0; a_addr = 0; a_data = 0;
        b_req = 0; b_addr = 0; b_data = 0;
        clr_start = 0; clr_color = 0;
        tick(); tick();
        total++;
        if (outs() !== 21'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=%h", outs(), 21'd0);
        end
        rst_n = 1'b1;
        tick();
        total++;
        if (outs() !== 21'd0) begin
            bad++;
            $display("FAIL post_reset_idle got=%h want=%h", outs(), 21'd0);
        end
    endtask

    task automatic test_round_robin();
        logic [20:0] exp;
        a_req = 1; a_addr = 12'h100; a_data = 4'h1;
        b_req = 1; b_addr = 12'h200; b_data = 4'h2;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i % 2 == 0) exp = {5'b11000, 12'h100, 4'h1};
            else            exp = {5'b10100, 12'h200, 4'h2};
            total++;
            if (outs() !== exp) begin
                bad++;
                $display("FAIL rr_write%0d got=%h want=%h", i, outs(), exp);
            end
            if (i == 3) begin
                a_req = 0; b_req = 0;
            end
            tick();
            exp = {5'b00000, exp[15:0]};
            total++;
            if (outs() !== exp) begin
                bad++;
                $display("FAIL rr_idle%0d got=%h want=%h", i, outs(), exp);
            end
        end
    endtask

    task automatic test_single_a();
        a_req = 1; a_addr = 12'h041; a_data = 4'h5;
        tick();
        total++;
        if (outs() !== {5'b11000, 12'h041, 4'h5}) begin
            bad++;
            $display("FAIL single_a_write got=%h want=%h", outs(), {5'b11000, 12'h041, 4'h5});
        end
        a_req = 0;
        tick();
        total++;
        if (outs() !== {5'b00000, 12'h041, 4'h5}) begin
            bad++;
            $display("FAIL single_a_idle got=%h want=%h", outs(), {5'b00000, 12'h041, 4'h5});
        end
    endtask

    task automatic test_clear();
        int bad_cycles;
        int quiet_bad;
        clr_color = 4'h3; clr_start = 1;
        tick();
        total++;
        if (wren !== 1'b0 || clr_busy !== 1'b0) begin
            bad++;
            $display("FAIL clr_latch_cycle got wren=%b busy=%b want 0 0", wren, clr_busy);
        end
        clr_start = 0; clr_color = 4'h0;
        a_req = 1; a_addr = 12'h0AA; a_data = 4'h9;
        tick();
        bad_cycles = 0;
        for (int i = 0; i < 4096; i++) begin
            if (outs() !== {5'b10010, 12'(i), 4'h3}) begin
                bad_cycles++;
                if (bad_cycles == 1)
                    $display("note: first bad sweep cycle %0d got=%h", i, outs());
            end
            if (i == 100) begin
                clr_start = 1; clr_color = 4'hE;
            end else begin
                clr_start = 0;
            end
            tick();
        end
        total++;
        if (bad_cycles !== 0) begin
            bad++;
            $display("FAIL clear_sweep bad_cycles=%0d want 0", bad_cycles);
        end
        total++;
        if (outs() !== {5'b00001, 12'hFFF, 4'h3}) begin
            bad++;
            $display("FAIL clear_done got=%h want=%h", outs(), {5'b00001, 12'hFFF, 4'h3});
        end
        tick();
        total++;
        if (outs() !== {5'b11000, 12'h0AA, 4'h9}) begin
            bad++;
            $display("FAIL ack_after_clear got=%h want=%h", outs(), {5'b11000, 12'h0AA, 4'h9});
        end
        a_req = 0;
        quiet_bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (wren !== 1'b0 || clr_busy !== 1'b0 || clr_done !== 1'b0) quiet_bad++;
        end
        total++;
        if (quiet_bad !== 0) begin
            bad++;
            $display("FAIL no_second_sweep active_cycles=%0d want 0", quiet_bad);
        end
    endtask

    task automatic test_clear_during_write_and_abort();
        int guard;
        int post_bad;
        b_req = 1; b_addr = 12'h3C3; b_data = 4'h7;
        tick();
        total++;
        if (outs() !== {5'b10100, 12'h3C3, 4'h7}) begin
            bad++;
            $display("FAIL b_write got=%h want=%h", outs(), {5'b10100, 12'h3C3, 4'h7});
        end
        b_req = 0; clr_start = 1; clr_color = 4'h6;
        tick();
        clr_start = 0;
        total++;
        if (outs() !== {5'b00000, 12'h3C3, 4'h7}) begin
            bad++;
            $display("FAIL idle_between got=%h want=%h", outs(), {5'b00000, 12'h3C3, 4'h7});
        end
        tick();
        total++;
        if (outs() !== {5'b10010, 12'h000, 4'h6}) begin
            bad++;
            $display("FAIL clear_from_zero got=%h want=%h", outs(), {5'b10010, 12'h000, 4'h6});
        end
        guard = 0;
        while (waddr !== 12'h800 && guard < 3000) begin
            tick();
            guard++;
        end
        total++;
        if (guard !== 2048) begin
            bad++;
            $display("FAIL reach_0x800 cycles=%0d want 2048", guard);
        end
        rst_n = 0;
        #1;
        total++;
        if (outs() !== 21'd0) begin
            bad++;
            $display("FAIL async_reset got=%h want=%h", outs(), 21'd0);
        end
        tick();
        rst_n = 1;
        post_bad = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (outs() !== 21'd0) post_bad++;
        end
        total++;
        if (post_bad !== 0) begin
            bad++;
            $display("FAIL post_abort_idle active_cycles=%0d want 0", post_bad);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_a();
        test_clear();
        test_clear_during_write_and_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
